uarttx_scheduler: RTL and testbench

UARTTX_SCHEDULER -- requirements
Module: uarttx_scheduler

---
 rtl/uarttx_sched_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 20 ++
 rtl/uarttx_scheduler.sv | 86 ++++++++
 tb/tb_uarttx_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uarttx_sched_pkg.sv
// uarttx_sched_pkg: FSM states and CSR map shared by the UART TX scheduler.
package uarttx_sched_pkg;
  typedef enum logic [2:0] {INIT, ARB, POLL_RD, POLL_CHK, WR, GUARD} state_t;
  localparam logic [5:0] ADDR_CONTROL = 6'h00;
  localparam logic [5:0] ADDR_TXDATA = 6'h04;
  localparam logic [5:0] ADDR_STATUS = 6'h08;
  localparam int STATUS_TX_READY = 0;
  localparam logic [31:0] CONTROL_EN = 32'h1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick starting one past the last grant.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [1:0]      win,
  output logic            found
);
  always_comb begin
    win = last;
    found = 1'b0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req[(int'(last) + i) % NREQ]) begin
        win = 2'((int'(last) + i) % NREQ);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uarttx_scheduler.sv
// uarttx_scheduler: arbitrates byte requesters and feeds a CSR-mapped UART TX,
// polling STATUS before each TXDATA write and dropping bytes on poll timeout.
module uarttx_scheduler
  import uarttx_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int GUARD_CYC = 4,
  parameter int POLL_MAX = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              o_en,
  output logic              o_wen,
  output logic [3:0]        o_byteen,
  output logic [5:0]        o_addr,
  output logic [31:0]       o_wdata,
  input  logic [31:0]       i_rdata,
  output logic              o_init_done,
  output logic              o_busy,
  output logic              o_drop,
  output logic [1:0]        o_grant_id
);
  state_t state, state_n;
  logic [7:0] hold;
  logic [15:0] cnt;
  logic [3:0] gcnt;
  logic [1:0] last, win;
  logic found, rdy, timeout;
  rr_arbiter #(.NREQ(NREQ)) u_arb (.req(req_valid), .last(last), .win(win), .found(found));
  assign rdy = i_rdata[STATUS_TX_READY];
  assign timeout = !rdy && cnt >= 16'(POLL_MAX);
  assign req_ready = {{(NREQ-1){1'b0}}, state == ARB && found} << win;
  // INIT stays until its CONTROL write has actually been presented on the bus
  always_comb begin
    state_n = state;
    case (state)
      INIT:     state_n = o_en ? ARB : INIT;
      ARB:      state_n = found ? POLL_RD : ARB;
      POLL_RD:  state_n = POLL_CHK;
      POLL_CHK: state_n = rdy ? WR : timeout ? ARB : POLL_RD;
      WR:       state_n = GUARD;
      GUARD:    state_n = gcnt == 4'(GUARD_CYC-1) ? ARB : GUARD;
      default:  state_n = INIT;
    endcase
  end
  // bus outputs decode the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      o_en <= 1'b0;
      o_wen <= 1'b0;
      o_byteen <= 4'h0;
      o_addr <= 6'h0;
      o_wdata <= 32'h0;
      o_init_done <= 1'b0;
      o_busy <= 1'b0;
      o_drop <= 1'b0;
      o_grant_id <= 2'h0;
      hold <= 8'h0;
      cnt <= 16'h0;
      gcnt <= 4'h0;
      last <= 2'(NREQ-1);
    end else begin
      state <= state_n;
      o_en <= state_n inside {INIT, POLL_RD, WR};
      o_wen <= state_n inside {INIT, WR};
      o_byteen <= state_n inside {INIT, WR} ? 4'h1 : 4'h0;
      o_addr <= state_n == INIT ? ADDR_CONTROL : state_n == POLL_RD ? ADDR_STATUS : state_n == WR ? ADDR_TXDATA : 6'h0;
      o_wdata <= state_n == INIT ? CONTROL_EN : state_n == WR ? {24'h0, hold} : 32'h0;
      o_busy <= state_n inside {POLL_RD, POLL_CHK, WR, GUARD};
      o_drop <= state == POLL_CHK && timeout;
      o_init_done <= o_init_done | (state == INIT && o_en);
      gcnt <= state == GUARD ? gcnt + 4'h1 : 4'h0;
      if (state == POLL_RD && cnt != 16'hffff) cnt <= cnt + 16'h1;
      if (state == ARB && found) begin
        hold <= req_data[8*win +: 8];
        o_grant_id <= win;
        last <= win;
        cnt <= 16'h0;
      end
    end
  end
endmodule

// File: tb/tb_uarttx_scheduler.sv
// tb_uarttx_scheduler: scoreboard bench with a registered CSR/UART model.
module tb_uarttx_scheduler;
  import uarttx_sched_pkg::*;
  logic clk = 0, rst = 1;
  logic [1:0] req_valid = 0, req_ready, o_grant_id;
  logic [15:0] req_data = 0;
  logic o_en, o_wen, o_init_done, o_busy, o_drop;
  logic [3:0] o_byteen;
  logic [5:0] o_addr;
  logic [31:0] o_wdata, i_rdata = 0;
  int tests = 0, fails = 0, cyc = 0, rd_cnt = 0, rd_since = 0;
  int wr_cnt = 0, ctrl_cnt = 0, drop_cnt = 0, last_wr_cyc = 0, nr_target = 0;
  bit stuck = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int wr_cyc_q[$];

  uarttx_scheduler #(.NREQ(2), .GUARD_CYC(4), .POLL_MAX(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .o_en(o_en), .o_wen(o_wen), .o_byteen(o_byteen), .o_addr(o_addr), .o_wdata(o_wdata),
    .i_rdata(i_rdata), .o_init_done(o_init_done), .o_busy(o_busy), .o_drop(o_drop),
    .o_grant_id(o_grant_id)
  );

  always #5 clk = ~clk;

  // UART CSR model: STATUS reports ready once nr_target reads have gone by
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rd_since <= 0;
    else if ((o_en && o_wen && o_addr == ADDR_TXDATA) || o_drop) rd_since <= 0;
    else if (o_en && !o_wen && o_addr == ADDR_STATUS) begin
      i_rdata <= {31'h0, !stuck && rd_since >= nr_target};
      rd_since <= rd_since + 1;
      rd_cnt <= rd_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && o_drop) drop_cnt++;
    if (!rst && o_en && o_wen && o_addr == ADDR_CONTROL) begin
      ctrl_cnt++;
      tests++;
      if (o_wdata !== CONTROL_EN || o_byteen !== 4'h1) begin
        fails++;
        $display("FAIL ctrl_write: wdata=%h byteen=%h, want 00000001/1", o_wdata, o_byteen);
      end
    end
    if (!rst && o_en && o_wen && o_addr == ADDR_TXDATA) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      wr_cyc_q.push_back(cyc);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL txdata_unexpected: wdata=%h with no byte expected", o_wdata);
      end else begin
        exp_b = exp_q.pop_front();
        if (o_wdata !== {24'h0, exp_b} || o_byteen !== 4'h1) begin
          fails++;
          $display("FAIL txdata: wdata=%h byteen=%h, want %h/1", o_wdata, o_byteen, exp_b);
        end
      end
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1;
    req_valid = 0;
    exp_q.delete();
    repeat (3) step();
    rst = 0;
    repeat (4) step();
  endtask

  task automatic send(input int k, input logic [7:0] d, input bit expect_wr, output int c0, output bit ok);
    req_data[8*k +: 8] = d;
    req_valid[k] = 1'b1;
    if (expect_wr) exp_q.push_back(d);
    ok = 0;
    c0 = 0;
    #1;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (req_ready[k]) begin
        ok = 1;
        c0 = cyc;
      end else step();
    end
    if (ok) step();
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_wr(input int target);
    for (int i = 0; i < 100 && wr_cnt < target; i++) step();
  endtask

  task automatic test_reset;
    int c0;
    rst = 1;
    req_valid = 2'b11;
    req_data = 16'hB1A0;
    repeat (3) step();
    tests++;
    if (req_ready !== 2'b00) begin
      fails++;
      $display("FAIL reset_ready: req_ready=%b, want 00", req_ready);
    end
    tests++;
    if ({o_en, o_wen, o_byteen, o_addr, o_wdata, o_init_done, o_busy, o_drop, o_grant_id} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: en=%b wen=%b be=%h addr=%h wdata=%h done=%b busy=%b drop=%b gid=%0d, want all 0",
               o_en, o_wen, o_byteen, o_addr, o_wdata, o_init_done, o_busy, o_drop, o_grant_id);
    end
    req_valid = 0;
    c0 = ctrl_cnt;
    rst = 0;
    for (int i = 0; i < 10 && ctrl_cnt == c0; i++) step();
    tests++;
    if (o_init_done !== 1'b0) begin
      fails++;
      $display("FAIL init_done_early: got %b during CONTROL write, want 0", o_init_done);
    end
    step();
    tests++;
    if (o_init_done !== 1'b1) begin
      fails++;
      $display("FAIL init_done: got %b after CONTROL write, want 1", o_init_done);
    end
    repeat (10) step();
    tests++;
    if (ctrl_cnt != c0 + 1 || wr_cnt != 0 || rd_cnt != 0) begin
      fails++;
      $display("FAIL init_idle: ctrl=%0d wr=%0d rd=%0d, want 1/0/0", ctrl_cnt - c0, wr_cnt, rd_cnt);
    end
  endtask

  task automatic test_latency;
    int c0, w0;
    bit ok;
    w0 = wr_cnt;
    nr_target = 0;
    send(0, 8'h41, 1, c0, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL latency_grant: req_ready[0] never seen");
    end
    wait_wr(w0 + 1);
    tests++;
    if (wr_cnt != w0 + 1 || last_wr_cyc - c0 != 3) begin
      fails++;
      $display("FAIL latency: writes=%0d delay=%0d, want 1/3", wr_cnt - w0, last_wr_cyc - c0);
    end
    while (cyc < c0 + 7) step();
    tests++;
    if (o_busy !== 1'b1 || o_grant_id !== 2'd0) begin
      fails++;
      $display("FAIL busy_guard: busy=%b gid=%0d at last guard cycle, want 1/0", o_busy, o_grant_id);
    end
    step();
    tests++;
    if (o_busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_clear: busy=%b after guard, want 0", o_busy);
    end
  endtask

  task automatic test_back_to_back;
    int w0;
    do_reset();
    w0 = wr_cnt;
    wr_cyc_q.delete();
    req_data = 16'hB1A0;
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hB1);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hB1);
    req_valid = 2'b11;
    wait_wr(w0 + 4);
    req_valid = 2'b00;
    tests++;
    if (wr_cnt != w0 + 4 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_count: writes=%0d left=%0d, want 4/0", wr_cnt - w0, exp_q.size());
    end
    tests++;
    if (wr_cyc_q.size() < 4) begin
      fails++;
      $display("FAIL b2b_spacing: only %0d writes recorded, want 4", wr_cyc_q.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        if (wr_cyc_q[i] - wr_cyc_q[i-1] != 8) begin
          fails++;
          $display("FAIL b2b_spacing: gap %0d is %0d cycles, want 8", i, wr_cyc_q[i] - wr_cyc_q[i-1]);
        end
      end
    end
    repeat (12) step();
    tests++;
    if (wr_cnt != w0 + 4 || o_grant_id !== 2'd1 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: writes=%0d gid=%0d busy=%b, want 4/1/0", wr_cnt - w0, o_grant_id, o_busy);
    end
  endtask

  task automatic test_slow_status;
    int c0, w0, r0, d0;
    bit ok;
    nr_target = 3;
    w0 = wr_cnt;
    r0 = rd_cnt;
    d0 = drop_cnt;
    send(0, 8'h5C, 1, c0, ok);
    wait_wr(w0 + 1);
    tests++;
    if (!ok || wr_cnt != w0 + 1 || rd_cnt - r0 != 4 || drop_cnt != d0) begin
      fails++;
      $display("FAIL slow_status: granted=%b writes=%0d reads=%0d drops=%0d, want 1/1/4/0",
               ok, wr_cnt - w0, rd_cnt - r0, drop_cnt - d0);
    end
    nr_target = 0;
    repeat (8) step();
  endtask

  task automatic test_timeout;
    int c0, w0, r0, d0;
    bit ok;
    stuck = 1;
    w0 = wr_cnt;
    r0 = rd_cnt;
    d0 = drop_cnt;
    send(0, 8'h77, 0, c0, ok);
    for (int i = 0; i < 100 && drop_cnt == d0; i++) step();
    tests++;
    if (drop_cnt != d0 + 1 || rd_cnt - r0 != 4 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_drop: drops=%0d reads=%0d busy=%b, want 1/4/0", drop_cnt - d0, rd_cnt - r0, o_busy);
    end
    step();
    tests++;
    if (o_drop !== 1'b0 || drop_cnt != d0 + 1 || wr_cnt != w0) begin
      fails++;
      $display("FAIL timeout_pulse: drop=%b drops=%0d writes=%0d, want 0/1/0", o_drop, drop_cnt - d0, wr_cnt - w0);
    end
    stuck = 0;
    send(0, 8'h33, 1, c0, ok);
    wait_wr(w0 + 1);
    tests++;
    if (wr_cnt != w0 + 1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL after_timeout: writes=%0d left=%0d, want 1/0", wr_cnt - w0, exp_q.size());
    end
    repeat (8) step();
  endtask

  task automatic test_reset_midway;
    int c0, w0, r0, ct0;
    bit ok;
    nr_target = 2;
    w0 = wr_cnt;
    r0 = rd_cnt;
    send(0, 8'h99, 0, c0, ok);
    for (int i = 0; i < 20 && rd_cnt == r0; i++) step();
    tests++;
    if (o_busy !== 1'b1 || o_en !== 1'b0) begin
      fails++;
      $display("FAIL mid_pollchk: busy=%b en=%b, want 1/0", o_busy, o_en);
    end
    rst = 1;
    repeat (2) step();
    tests++;
    if (o_busy !== 1'b0 || o_init_done !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: busy=%b done=%b, want 0/0", o_busy, o_init_done);
    end
    ct0 = ctrl_cnt;
    rst = 0;
    for (int i = 0; i < 10 && ctrl_cnt == ct0; i++) step();
    tests++;
    if (o_init_done !== 1'b0 || ctrl_cnt != ct0 + 1) begin
      fails++;
      $display("FAIL mid_reinit: done=%b ctrl=%0d, want 0/1", o_init_done, ctrl_cnt - ct0);
    end
    step();
    tests++;
    if (o_init_done !== 1'b1) begin
      fails++;
      $display("FAIL mid_done: done=%b, want 1", o_init_done);
    end
    repeat (20) step();
    tests++;
    if (wr_cnt != w0 || ctrl_cnt != ct0 + 1) begin
      fails++;
      $display("FAIL mid_discard: writes=%0d ctrl=%0d, want 0/1", wr_cnt - w0, ctrl_cnt - ct0);
    end
    nr_target = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_slow_status();
    test_timeout();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
